shift_exec_stage: RTL

//  Execute-stage wrapper around the SHIFTX32 barrel shifter for MIPS R-type shifts
//  (SLL/SRL/SRA/SLLV/SRLV/SRAV). Decodes funct, selects the shift amount (shamt

---
 rtl/shift_exec_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/shift_exec_stage.sv
// Execute-stage shift unit for MIPS R-type shifts.
// Decodes funct, drives a combinational 32-bit barrel shifter and queues results
// in a small in-order FIFO with valid/ready on both sides plus a pipeline flush.

// Combinational 32-bit barrel shifter: left logical, right logical, right arithmetic.
module shiftX32 (
  input  logic [31:0] x,
  input  logic [4:0]  sa,
  input  logic        right,
  input  logic        arith,
  output logic [31:0] y
);
  // Pick the shift flavour; arith only matters for right shifts.
  always_comb begin
    if (!right)     y = x << sa;
    else if (arith) y = $signed(x) >>> sa;
    else            y = x >> sa;
  end
endmodule

module shift_exec_stage #(
  parameter int DEPTH = 2,
  parameter int RD_W  = 5
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [5:0]      Funct,
  input  logic [4:0]      Shamt,
  input  logic [31:0]     Rs,
  input  logic [31:0]     Rt,
  input  logic [RD_W-1:0] Rd,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [31:0]     OutY,
  output logic [RD_W-1:0] OutRd,
  output logic            OutIllegal
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0]     y;
    logic [RD_W-1:0] rd;
    logic            illegal;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;

  logic [4:0]  sa;
  logic        right, arith, legal;
  logic [31:0] shY;
  logic        push, pop;

  // Only the low five bits of Rs form a shift amount.
  logic unusedRsHi;
  assign unusedRsHi = ^Rs[31:5];

  // Funct decode: shift direction/kind and where the amount comes from.
  always_comb begin
    sa    = Shamt;
    right = 1'b0;
    arith = 1'b0;
    legal = 1'b1;
    case (Funct)
      6'b000000: ;
      6'b000010: right = 1'b1;
      6'b000011: begin right = 1'b1; arith = 1'b1; end
      6'b000100: sa = Rs[4:0];
      6'b000110: begin sa = Rs[4:0]; right = 1'b1; end
      6'b000111: begin sa = Rs[4:0]; right = 1'b1; arith = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end

  shiftX32 uShift (.x(Rt), .sa(sa), .right(right), .arith(arith), .y(shY));

  // Ready comes from registered occupancy only, so no OutReady->InReady path.
  assign InReady  = (count != FULL);
  assign OutValid = (count != '0);
  assign push     = InValid & InReady & ~Flush;
  assign pop      = OutValid & OutReady;

  // Head outputs read zero whenever the FIFO is empty.
  always_comb begin
    OutY       = '0;
    OutRd      = '0;
    OutIllegal = 1'b0;
    if (OutValid) begin
      OutY       = mem[rdPtr].y;
      OutRd      = mem[rdPtr].rd;
      OutIllegal = mem[rdPtr].illegal;
    end
  end

  // FIFO state: reset beats flush, flush clears everything including a same-cycle accept.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (Flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= '{y: legal ? shY : 32'h0, rd: Rd, illegal: ~legal};
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule
